// File: rtl/execute_stage_mc.sv
// execute_stage_mc: forwarded-operand ALU plus an iterative shift-add multiplier feeding the EX/MEM register.
// Optional macro EX_OVERFLOW_EN builds signed ADD/SUB overflow detection onto exmem_overflow.

module execute_stage_mc #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [3:0]       alu_op,
  input  logic             alusrc,
  input  logic             branch_in,
  input  logic [WIDTH-1:0] reg1_data,
  input  logic [WIDTH-1:0] reg2_data,
  input  logic [WIDTH-1:0] immediate_in,
  input  logic [WIDTH-1:0] exmem_fwd_data,
  input  logic [WIDTH-1:0] memwb_fwd_data,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic [RA_W-1:0]  rd_in,
  input  logic             regwrite_in,
  input  logic             memread_in,
  input  logic             memwrite_in,
  input  logic             memtoreg_in,
  output logic             stall_out,
  output logic             busy,
  output logic             exmem_valid,
  output logic [WIDTH-1:0] exmem_alu_out,
  output logic [WIDTH-1:0] exmem_store_data,
  output logic [RA_W-1:0]  exmem_rd,
  output logic             exmem_regwrite,
  output logic             exmem_memread,
  output logic             exmem_memwrite,
  output logic             exmem_memtoreg,
  output logic             exmem_branch_taken,
  output logic             exmem_overflow
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [SH_W-1:0]  r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] r_opb;

  logic             r_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic [WIDTH-1:0] r_store;
  logic [RA_W-1:0]  r_rd;
  logic             r_regwrite;
  logic             r_memread;
  logic             r_memwrite;
  logic             r_memtoreg;
  logic             r_branch_taken;

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_op2;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_store;
  logic             w_is_mul;
  logic             w_stall;
  logic             w_load;
  logic             w_zero;

  function automatic logic [WIDTH-1:0] alu_f(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      OP_ADD:   alu_f = a + b;
      OP_SUB:   alu_f = a - b;
      OP_AND:   alu_f = a & b;
      OP_OR:    alu_f = a | b;
      OP_XOR:   alu_f = a ^ b;
      OP_SLL:   alu_f = a << sh;
      OP_SRL:   alu_f = a >> sh;
      OP_SRA:   alu_f = $signed(a) >>> sh;
      OP_SLT:   alu_f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASSB: alu_f = b;
      default:  alu_f = {WIDTH{1'b0}};
    endcase
  endfunction

`ifdef EX_OVERFLOW_EN
  function automatic logic ovf_f(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r
  );
    case (op)
      OP_ADD:  ovf_f = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  ovf_f = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: ovf_f = 1'b0;
    endcase
  endfunction
`endif

  // Operand forwarding muxes and the immediate select for operand 2.
  always_comb begin
    w_op_a = {WIDTH{1'b0}};
    w_op_b = {WIDTH{1'b0}};
    case (forward_a)
      2'b00:   w_op_a = reg1_data;
      2'b01:   w_op_a = memwb_fwd_data;
      2'b10:   w_op_a = exmem_fwd_data;
      default: w_op_a = {WIDTH{1'b0}};
    endcase
    case (forward_b)
      2'b00:   w_op_b = reg2_data;
      2'b01:   w_op_b = memwb_fwd_data;
      2'b10:   w_op_b = exmem_fwd_data;
      default: w_op_b = {WIDTH{1'b0}};
    endcase
    if (alusrc) begin
      w_op2 = immediate_in;
    end else begin
      w_op2 = w_op_b;
    end
  end

  // Result selection, stall generation and EX/MEM load decision.
  always_comb begin
    w_is_mul  = in_valid && (alu_op == OP_MUL);
    w_stall   = rst && w_is_mul && (r_state != ST_DONE) && !flush;
    w_alu_res = alu_f(alu_op, w_op_a, w_op2);
    if (r_state == ST_DONE) begin
      w_result = r_prod;
      w_store  = r_opb;
    end else begin
      w_result = w_alu_res;
      w_store  = w_op_b;
    end
    w_zero = (w_result == {WIDTH{1'b0}});
    // DONE delivers the product from held state even if upstream has wandered.
    w_load = !flush && ((r_state == ST_DONE) || (in_valid && !w_stall));
  end

  // Multiplier FSM: capture in IDLE, one shift-add step per edge in MUL, hand off in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {SH_W{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_prod   <= {WIDTH{1'b0}};
      r_opb    <= {WIDTH{1'b0}};
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= {SH_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mul) begin
            r_mcand  <= w_op_a;
            r_mplier <= w_op2;
            r_opb    <= w_op_b;
            r_prod   <= {WIDTH{1'b0}};
            r_cnt    <= {SH_W{1'b0}};
            r_state  <= ST_MUL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end else begin
            r_prod <= r_prod;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + SH_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_MUL;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= {SH_W{1'b0}};
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {SH_W{1'b0}};
        end
      endcase
    end
  end

  // EX/MEM pipeline register: real instruction or an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid        <= 1'b0;
      r_alu_out      <= {WIDTH{1'b0}};
      r_store        <= {WIDTH{1'b0}};
      r_rd           <= {RA_W{1'b0}};
      r_regwrite     <= 1'b0;
      r_memread      <= 1'b0;
      r_memwrite     <= 1'b0;
      r_memtoreg     <= 1'b0;
      r_branch_taken <= 1'b0;
    end else if (w_load) begin
      r_valid        <= 1'b1;
      r_alu_out      <= w_result;
      r_store        <= w_store;
      r_rd           <= rd_in;
      r_regwrite     <= regwrite_in;
      r_memread      <= memread_in;
      r_memwrite     <= memwrite_in;
      r_memtoreg     <= memtoreg_in;
      r_branch_taken <= branch_in && w_zero;
    end else begin
      r_valid        <= 1'b0;
      r_alu_out      <= {WIDTH{1'b0}};
      r_store        <= {WIDTH{1'b0}};
      r_rd           <= {RA_W{1'b0}};
      r_regwrite     <= 1'b0;
      r_memread      <= 1'b0;
      r_memwrite     <= 1'b0;
      r_memtoreg     <= 1'b0;
      r_branch_taken <= 1'b0;
    end
  end

`ifdef EX_OVERFLOW_EN
  logic r_overflow;

  // Overflow flag registered alongside the result; the multiplier never flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_load && (r_state != ST_DONE)) begin
      r_overflow <= ovf_f(alu_op, w_op_a, w_op2, w_alu_res);
    end else begin
      r_overflow <= 1'b0;
    end
  end

  assign exmem_overflow = r_overflow;
`else
  assign exmem_overflow = 1'b0;
`endif

  assign stall_out          = w_stall;
  assign busy               = (r_state != ST_IDLE);
  assign exmem_valid        = r_valid;
  assign exmem_alu_out      = r_alu_out;
  assign exmem_store_data   = r_store;
  assign exmem_rd           = r_rd;
  assign exmem_regwrite     = r_regwrite;
  assign exmem_memread      = r_memread;
  assign exmem_memwrite     = r_memwrite;
  assign exmem_memtoreg     = r_memtoreg;
  assign exmem_branch_taken = r_branch_taken;

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
Parametrised pipelined execute stage for the MIPS-style core. It selects forwarded operands and runs a single-cycle ALU or a multi-cycle iterative multiplier. Results and control go into an internal EX/MEM pipeline register. The block sits between the ID/EX register and the memory stage, and raises a stall to the hazard unit while a multiply is in progress.

Parameters:
WIDTH, 16, datapath width in bits (≥4, power of two)
RA_W, 3, register-address width
SH_W, $clog2(WIDTH), shift-amount bits taken from operand2[SH_W-1:0]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  ID/EX holds a valid instruction
flush  in  1  synchronous kill of the current EX instruction
alu_op  in  4  operation code (see Behaviour)
alusrc  in  1  1: operand2 = immediate_in
branch_in  in  1  instruction is a branch-on-zero
reg1_data, reg2_data  in  WIDTH  register-file operands
immediate_in  in  WIDTH  sign-extended immediate
exmem_fwd_data, memwb_fwd_data  in  WIDTH  forwarding sources
forward_a, forward_b  in  2  00 reg, 01 MEM/WB, 10 EX/MEM, 11 zero
rd_in  in  RA_W  destination register
regwrite_in, memread_in, memwrite_in, memtoreg_in  in  1  control bits to forward
stall_out  out  1  upstream must hold ID/EX contents
busy  out  1  multiplier state ≠ IDLE
exmem_valid  out  1  EX/MEM register holds a real instruction
exmem_alu_out  out  WIDTH  registered result
exmem_store_data  out  WIDTH  registered forwarded operand B (before the alusrc mux)
exmem_rd  out  RA_W  registered rd
exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg  out  1  registered control
exmem_branch_taken  out  1  registered branch_in & (result == 0)
exmem_overflow  out  1  see Optional Feature

Behaviour:
- Reset (rst=0, async): all exmem_* outputs = 0, state = IDLE, counter = 0. stall_out and busy = 0.
- Operand A is selected by forward_a and operand B by forward_b (00/01/10/11 as in Ports). Operand2 = alusrc ? immediate_in : operand B.
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed; result 1 or 0), 9 MUL (low WIDTH bits of the product), 10 PASSB (operand2), 11–15 result 0.
- Arithmetic wraps modulo 2^WIDTH. Shifts use operand2[SH_W-1:0].
- Single-cycle ops have 1-cycle latency: the EX/MEM register loads at the next edge whenever stall_out = 0.
- A cycle with in_valid = 0 loads a bubble: valid and all control bits = 0, data = 0.
- Multiplier FSM has states IDLE, MUL and DONE. It runs shift-add, one bit per cycle.
  - IDLE: in_valid & op=9 & ~flush → capture operand A and operand2, counter = 0, go to MUL. stall_out = 1 combinationally in this cycle.
  - MUL: stall_out = 1. One iteration per edge. After WIDTH iterations go to DONE.
  - DONE: stall_out = 0. The edge loads the product into EX/MEM (valid = 1, with control) and returns to IDLE.
  - A MUL stalls for exactly WIDTH+1 cycles.
- While stall_out = 1, the EX/MEM register loads a bubble every edge.
- stall_out = in_valid & (alu_op == 9) & (state ≠ DONE).
- Operands are captured only in IDLE. Upstream forwarding changes during MUL or DONE are ignored for the data path. Control bits come from the held inputs in DONE.
- flush = 1 has highest priority: EX/MEM loads a bubble, state goes to IDLE, counter = 0, and stall_out is forced to 0 in that cycle.
- exmem_branch_taken uses the zero flag of the same result that is loaded. It is 0 for bubbles.

Optional Feature:
Macro EX_OVERFLOW_EN.
- Defined: exmem_overflow is registered with the result. It is 1 when a valid ADD or SUB has signed two's-complement overflow, and 0 otherwise, including for bubbles.
- Undefined: no overflow logic is built and exmem_overflow is tied to 0.

Test Plan:
- ADD with forward_a=10, exmem_fwd_data=0x0005, reg2_data=0x0003, forward_b=00, rd_in=2, regwrite=1 → next edge: exmem_alu_out=0x0008, exmem_rd=2, exmem_valid=1.
- SUB with 0x0007−0x0007 and branch_in=1 → exmem_alu_out=0, exmem_branch_taken=1. Repeat with 0x0007−0x0006 → exmem_branch_taken=0.
- MUL 0x0012×0x0034 (WIDTH=16) held valid → stall_out high exactly 17 cycles, with bubbles in EX/MEM throughout. Then exmem_alu_out=0x03A8, valid=1. Also 0xFFFF×0xFFFF → 0x0001.
- flush asserted during the 5th MUL cycle → stall_out=0, busy=0 next cycle, EX/MEM holds a bubble, no product is ever loaded. Same check with rst pulsed low mid-MUL: all outputs 0 immediately.
- Shifts and SLT: SRA 0x8000 by operand2=0x0013 (amount 3) → 0xF000. SLT 0xFFFF vs 0x0001 → 0x0001. alu_op=12 → 0x0000. forward_b=11 → operand B 0.
- EX_OVERFLOW_EN defined: ADD 0x7FFF+0x0001 → exmem_overflow=1, result 0x8000. Undefined: exmem_overflow=0.
